// File: rtl/alu_issue_ctrl.sv
// Sequencer that queues ALU requests, issues them one at a time to a
// combinational ALU, waits a settle time and presents the captured result.
module alu_issue_ctrl #(
  parameter int W       = 4,
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [W-1:0]               in_a,
  input  logic [W-1:0]               in_b,
  input  logic [2:0]                 in_opcode,
  output logic [W-1:0]               alu_a,
  output logic [W-1:0]               alu_b,
  output logic [2:0]                 alu_opcode,
  input  logic [W-1:0]               alu_result,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [W-1:0]               out_result,
  output logic [2:0]                 out_opcode,
  output logic                       out_err,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW   = $clog2(DEPTH) + 1;
  localparam int EW   = 2 * W + 3;
  localparam int CNTW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESULT
  } state_t;

  state_t            state_reg;
  logic [CNTW-1:0]   cnt_reg;
  logic [EW-1:0]     mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [CW-1:0]     count_reg;
  logic [W-1:0]      alu_a_reg;
  logic [W-1:0]      alu_b_reg;
  logic [2:0]        alu_opcode_reg;
  logic [W-1:0]      out_result_reg;
  logic [2:0]        out_opcode_reg;
  logic              out_err_reg;
  logic              out_valid_reg;

  logic              push;
  logic              pop;
  logic [EW-1:0]     head;
  logic [W-1:0]      head_a;
  logic [W-1:0]      head_b;
  logic [2:0]        head_op;
  logic              head_legal;

  assign in_ready   = (count_reg < CW'(DEPTH));
  assign push       = in_valid && in_ready;
  // Pop decision uses the pre-edge occupancy, so a request is never issued in its push cycle.
  assign pop        = (state_reg == ST_IDLE) && (count_reg != '0);
  assign head       = mem[rd_ptr_reg];
  assign head_a     = head[EW-1 -: W];
  assign head_b     = head[W+2 -: W];
  assign head_op    = head[2:0];
  assign head_legal = (head_op <= 3'd4);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {in_a, in_b, in_opcode};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (push && !pop) begin
        count_reg <= count_reg + 1'b1;
      end else if (pop && !push) begin
        count_reg <= count_reg - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      alu_a_reg      <= '0;
      alu_b_reg      <= '0;
      alu_opcode_reg <= '0;
      out_result_reg <= '0;
      out_opcode_reg <= '0;
      out_err_reg    <= 1'b0;
      out_valid_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (pop) begin
            if (head_legal) begin
              alu_a_reg      <= head_a;
              alu_b_reg      <= head_b;
              alu_opcode_reg <= head_op;
              cnt_reg        <= CNTW'(ALU_LAT - 1);
              state_reg      <= ST_WAIT;
            end else begin
              // Illegal ops bypass the ALU entirely; alu_* keep the last legal op.
              out_result_reg <= '0;
              out_err_reg    <= 1'b1;
              out_opcode_reg <= head_op;
              out_valid_reg  <= 1'b1;
              state_reg      <= ST_RESULT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_reg == '0) begin
            out_result_reg <= alu_result;
            out_err_reg    <= 1'b0;
            out_opcode_reg <= alu_opcode_reg;
            out_valid_reg  <= 1'b1;
            state_reg      <= ST_RESULT;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        ST_RESULT: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= ST_IDLE;
          end
        end
        default: begin
          state_reg     <= ST_IDLE;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign alu_a      = alu_a_reg;
  assign alu_b      = alu_b_reg;
  assign alu_opcode = alu_opcode_reg;
  assign out_valid  = out_valid_reg;
  assign out_result = out_result_reg;
  assign out_opcode = out_opcode_reg;
  assign out_err    = out_err_reg;
  assign busy       = (state_reg != ST_IDLE) || (count_reg != '0);
  assign fifo_count = count_reg;

endmodule
